fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control FSM that sequences the shared 8-bit bus and the load-enable registers (MAR, IR, IMM) through instruction fetch, optional immediate fetch, and hand-off to execute. It drives the PC/memory bus-output enables and the MAR/IR/IMM load strobes, and runs a request/ready handshake with memory and a start/done handshake with the execute unit. It sits between the program counter, memory and the datapath registers, and is the sole owner of their load and output-enable controls during fetch.

## Interface
- TIMEOUT, default 16: max cycles waiting for mem_ready in a read state before faulting (legal range 2..255).
- clk  input  1  clock, all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- run  input  1  level; 1 = fetch instructions, 0 = stop at the next instruction boundary.
- halt_req  input  1  level; sampled only when execute completes; 1 = enter HALTED.
- ir  input  8  IR register output; ir[7]=1 marks a two-byte instruction (immediate follows).
- mem_ready  input  1  memory has read data valid on the bus this cycle.
- exec_done  input  1  execute unit finished the current instruction.
- pc_out_en  output  1  PC drives the bus.
- mar_load  output  1  load enable for MAR.
- mem_rd  output  1  memory read request.
- mem_out_en  output  1  memory drives the bus.
- ir_load  output  1  load enable for IR.
- imm_load  output  1  load enable for IMM.
- pc_inc  output  1  increment PC at this edge.
- exec_start  output  1  one-cycle pulse starting execute.
- busy  output  1  state is not IDLE, HALTED or ERROR.
- fault  output  1  sticky memory-timeout flag.
- instr_count  output  8  completed-instruction counter.
- state_dbg  output  3  encoded current state.

## Operation
- States and encoding: IDLE=0, ADDR=1, READ=2, DECODE=3, IADDR=4, IREAD=5, EXEC=6, HALTED=7; ERROR reuses encoding 7 with fault=1.
- IDLE: all strobes 0; run=1 -> ADDR.
- ADDR: pc_out_en=1, mar_load=1 for exactly one cycle -> READ.
- READ: mem_rd=1 every cycle. In the cycle mem_ready=1: mem_out_en=1, ir_load=1, pc_inc=1 (Mealy, qualified by mem_ready) -> DECODE.
- DECODE: one cycle, no strobes. ir[7]=1 -> IADDR, else -> EXEC.
- IADDR: pc_out_en=1, mar_load=1 for one cycle -> IREAD.
- IREAD: same as READ, except imm_load replaces ir_load. On mem_ready -> EXEC.
- EXEC: exec_start=1 in the first EXEC cycle only. exec_done is honoured in any EXEC cycle, including the exec_start cycle. On exec_done, instr_count increments (8-bit, FF wraps to 00), then:
  - halt_req=1 -> HALTED;
  - else run=0 -> IDLE;
  - else -> ADDR.
  - halt_req has priority over run.
- HALTED: all strobes 0; leaves only on reset.
- Timeout: a wait counter clears on entry to READ/IREAD and increments each cycle mem_ready=0. When it reaches TIMEOUT -> ERROR with fault=1, all strobes 0, mem_rd dropped. Left only by reset. The timeout counter is ceil(log2(TIMEOUT+1)) bits.
- run and halt_req are ignored except at the points listed above; run dropping mid-fetch does not abort the fetch.
- Strobes are mutually consistent: pc_out_en and mem_out_en are never 1 in the same cycle.

## Timing
- Reset (async): state IDLE; every output 0, including instr_count=0, fault=0, state_dbg=0. Reset asserted mid-operation drops all strobes immediately, without waiting for a clock edge.
- One-byte instruction, mem_ready=1 on its first cycle, exec_done in the start cycle: ADDR, READ, DECODE, EXEC = 4 cycles; back-to-back fetch with no IDLE gap.
- Two-byte instruction under the same conditions: 6 cycles.
- Each cycle mem_ready is late adds one cycle to READ/IREAD.
- With mem_ready held 0, entry to ERROR occurs TIMEOUT cycles after entering READ/IREAD.
- All outputs except the mem_ready-qualified strobes are decoded from the registered state only.

## Test plan
- Reset then run=1, ir=0x12, mem_ready always 1, exec_done=1 on exec_start -> strobe sequence {pc_out_en+mar_load}, {mem_rd+mem_out_en+ir_load+pc_inc}, {}, {exec_start}; repeats every 4 cycles; instr_count=1 after the first instruction.
- ir=0x85 -> IADDR/IREAD inserted; exactly one imm_load and two pc_inc per instruction; 6 cycles per instruction.
- mem_ready delayed 3 cycles in READ -> mem_rd held 4 cycles; ir_load only in the 4th cycle; no fault (TIMEOUT=16).
- mem_ready stuck 0 -> fault=1 and state_dbg=7 after 16 READ cycles; all strobes 0; fault stays set until reset, then fault=0.
- exec_done held off 5 cycles, halt_req=1 at done -> exec_start is a single pulse; HALTED reached, busy=0; run=1 does not restart; 256 completed instructions wrap instr_count to 0x00.
- Reset asserted mid-IREAD with mem_rd=1 -> all outputs 0 before the next edge; state_dbg=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch control FSM: sequences PC/memory bus drivers and MAR/IR/IMM load strobes
// through opcode fetch, optional immediate fetch and the execute hand-off.
module fetch_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       halt_req,
    input  logic [7:0] ir,
    input  logic       mem_ready,
    input  logic       exec_done,
    output logic       pc_out_en,
    output logic       mar_load,
    output logic       mem_rd,
    output logic       mem_out_en,
    output logic       ir_load,
    output logic       imm_load,
    output logic       pc_inc,
    output logic       exec_start,
    output logic       busy,
    output logic       fault,
    output logic [7:0] instr_count,
    output logic [2:0] state_dbg
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_IADDR  = 3'd4;
    localparam logic [2:0] S_IREAD  = 3'd5;
    localparam logic [2:0] S_EXEC   = 3'd6;
    // HALTED and ERROR share this encoding; fault_q tells them apart.
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          first_q, first_d;
    logic [7:0]    count_q, count_d;
    logic          fault_q, fault_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            first_q <= 1'b0;
            count_q <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            first_q <= first_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        first_d = 1'b0;
        count_d = count_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_ADDR;
            end
            S_ADDR: begin
                state_d = S_READ;
                wait_d  = '0;
            end
            S_IADDR: begin
                state_d = S_IREAD;
                wait_d  = '0;
            end
            S_READ, S_IREAD: begin
                if (mem_ready) begin
                    // first_d marks the exec_start cycle of the coming EXEC
                    if (state_q == S_READ) begin
                        state_d = S_DECODE;
                    end else begin
                        state_d = S_EXEC;
                        first_d = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (ir[7]) begin
                    state_d = S_IADDR;
                end else begin
                    state_d = S_EXEC;
                    first_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    count_d = count_q + 8'd1;
                    if (halt_req)  state_d = S_HALT;
                    else if (run)  state_d = S_ADDR;
                    else           state_d = S_IDLE;
                end
            end
            default: state_d = state_q;
        endcase
    end

    logic rd_state;
    assign rd_state = (state_q == S_READ) || (state_q == S_IREAD);

    assign pc_out_en   = (state_q == S_ADDR) || (state_q == S_IADDR);
    assign mar_load    = pc_out_en;
    assign mem_rd      = rd_state;
    assign mem_out_en  = rd_state && mem_ready;
    assign ir_load     = (state_q == S_READ) && mem_ready;
    assign imm_load    = (state_q == S_IREAD) && mem_ready;
    assign pc_inc      = rd_state && mem_ready;
    assign exec_start  = (state_q == S_EXEC) && first_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign fault       = fault_q;
    assign instr_count = count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: per-instruction expected strobe traces built from
// latency parameters, driven with randomized latencies, opcodes and don't-care inputs.
module tb_fetch_sequencer;

    localparam int TO = 16;

    // Strobe vector order: pc_out_en mar_load mem_rd mem_out_en ir_load imm_load pc_inc exec_start
    localparam logic [7:0] ST_NONE = 8'b0000_0000;
    localparam logic [7:0] ST_ADDR = 8'b1100_0000;
    localparam logic [7:0] ST_RDW  = 8'b0010_0000;
    localparam logic [7:0] ST_RDIR = 8'b0011_1010;
    localparam logic [7:0] ST_RDIM = 8'b0011_0110;
    localparam logic [7:0] ST_EXS  = 8'b0000_0001;

    logic       clk = 1'b0;
    logic       reset, run, halt_req, mem_ready, exec_done;
    logic [7:0] ir;
    logic       pc_out_en, mar_load, mem_rd, mem_out_en, ir_load, imm_load, pc_inc, exec_start;
    logic       busy, fault;
    logic [7:0] instr_count;
    logic [2:0] state_dbg;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] m_cnt = 8'd0;
    logic       m_fault = 1'b0;

    fetch_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .halt_req(halt_req), .ir(ir),
        .mem_ready(mem_ready), .exec_done(exec_done),
        .pc_out_en(pc_out_en), .mar_load(mar_load), .mem_rd(mem_rd),
        .mem_out_en(mem_out_en), .ir_load(ir_load), .imm_load(imm_load),
        .pc_inc(pc_inc), .exec_start(exec_start), .busy(busy), .fault(fault),
        .instr_count(instr_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_out(input string tag, input logic [7:0] es, input logic [2:0] est);
        logic [20:0] obs;
        logic [20:0] exp;
        obs = {pc_out_en, mar_load, mem_rd, mem_out_en, ir_load, imm_load, pc_inc,
               exec_start, busy, fault, state_dbg, instr_count};
        exp = {es, (est != 3'd0) && (est != 3'd7), m_fault, est, m_cnt};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check, advance.
    task automatic cyc(input string tag, input logic [7:0] es, input logic [2:0] est,
                       input logic mr, input logic ed, input bit noise);
        mem_ready = mr;
        exec_done = ed;
        if (noise) begin
            run      = 1'($urandom_range(0, 1));
            halt_req = 1'($urandom_range(0, 1));
        end
        #1;
        check_out(tag, es, est);
        @(negedge clk);
    endtask

    // Whole instruction: d1/d2 = late cycles of mem_ready, e = cycles before exec_done.
    task automatic instr(input logic [7:0] iv, input int d1, input int d2, input int e,
                         input logic h, input logic rn);
        ir = iv;
        cyc("addr", ST_ADDR, 3'd1, 1'($urandom_range(0, 1)), 1'b0, 1);
        for (int i = 0; i < d1; i++) cyc("read_wait", ST_RDW, 3'd2, 1'b0, 1'b0, 1);
        cyc("read", ST_RDIR, 3'd2, 1'b1, 1'b0, 1);
        cyc("decode", ST_NONE, 3'd3, 1'($urandom_range(0, 1)), 1'b0, 1);
        if (iv[7]) begin
            cyc("iaddr", ST_ADDR, 3'd4, 1'($urandom_range(0, 1)), 1'b0, 1);
            for (int i = 0; i < d2; i++) cyc("iread_wait", ST_RDW, 3'd5, 1'b0, 1'b0, 1);
            cyc("iread", ST_RDIM, 3'd5, 1'b1, 1'b0, 1);
        end
        for (int i = 0; i < e; i++)
            cyc("exec_wait", (i == 0) ? ST_EXS : ST_NONE, 3'd6, 1'($urandom_range(0, 1)), 1'b0, 1);
        halt_req = h;
        run      = rn;
        cyc("exec_done", (e == 0) ? ST_EXS : ST_NONE, 3'd6, 1'($urandom_range(0, 1)), 1'b1, 0);
        m_cnt = m_cnt + 8'd1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        m_cnt   = 8'd0;
        m_fault = 1'b0;
        check_out(tag, ST_NONE, 3'd0);
        @(negedge clk);
        reset    = 1'b0;
        run      = 1'b0;
        halt_req = 1'b0;
    endtask

    initial begin
        logic rn;
        run = 1'b0; halt_req = 1'b0; mem_ready = 1'b0; exec_done = 1'b0; ir = 8'h00;
        do_reset("reset_init");
        cyc("idle", ST_NONE, 3'd0, 1'b1, 1'b0, 0);
        run = 1'b1;
        cyc("idle_run", ST_NONE, 3'd0, 1'b0, 1'b0, 0);

        // Directed: back-to-back one-byte, two-byte, late memory
        repeat (3) instr(8'h12, 0, 0, 0, 1'b0, 1'b1);
        repeat (2) instr(8'h85, 0, 0, 0, 1'b0, 1'b1);
        instr(8'h34, 3, 0, 0, 1'b0, 1'b1);
        instr(8'h85, TO - 1, TO - 1, 0, 1'b0, 1'b1);

        // Randomized instructions, occasionally returning to IDLE
        for (int n = 0; n < 30; n++) begin
            rn = 1'($urandom_range(0, 3) != 0);
            instr(8'($urandom), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                  $urandom_range(0, 5), 1'b0, rn);
            if (!rn) begin
                run = 1'b0;
                cyc("idle_stop", ST_NONE, 3'd0, 1'b1, 1'b1, 0);
                run = 1'b1;
                cyc("idle_restart", ST_NONE, 3'd0, 1'b1, 1'b0, 0);
            end
        end

        // Memory timeout: mem_ready stuck low
        ir = 8'h12;
        cyc("to_addr", ST_ADDR, 3'd1, 1'b0, 1'b0, 1);
        for (int i = 0; i < TO; i++) cyc("to_read", ST_RDW, 3'd2, 1'b0, 1'b0, 1);
        m_fault = 1'b1;
        repeat (4) cyc("error", ST_NONE, 3'd7, 1'b1, 1'b1, 1);
        do_reset("reset_clears_fault");

        // Reset mid-IREAD drops strobes without a clock edge
        run = 1'b1;
        cyc("idle_run2", ST_NONE, 3'd0, 1'b0, 1'b0, 0);
        ir = 8'h85;
        cyc("m_addr", ST_ADDR, 3'd1, 1'b0, 1'b0, 1);
        cyc("m_read", ST_RDIR, 3'd2, 1'b1, 1'b0, 1);
        cyc("m_decode", ST_NONE, 3'd3, 1'b0, 1'b0, 1);
        cyc("m_iaddr", ST_ADDR, 3'd4, 1'b0, 1'b0, 1);
        cyc("m_iread1", ST_RDW, 3'd5, 1'b0, 1'b0, 1);
        mem_ready = 1'b0;
        #2;
        check_out("m_iread2", ST_RDW, 3'd5);
        do_reset("reset_mid_iread");

        // 256 instructions wrap the counter; last one halts after a delayed done
        run = 1'b1;
        cyc("idle_run3", ST_NONE, 3'd0, 1'b0, 1'b0, 0);
        for (int n = 0; n < 255; n++)
            instr(8'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 2), 1'b0, 1'b1);
        instr(8'h12, 0, 0, 5, 1'b1, 1'b1);
        run = 1'b1;
        halt_req = 1'b0;
        repeat (4) cyc("halted", ST_NONE, 3'd7, 1'b1, 1'b1, 0);
        checks++;
        assert (instr_count === 8'h00) else begin
            failures++;
            $error("FAIL wrap observed=%h expected=00", instr_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
